// File: rtl/closed_list_writer.sv
// Closed-list write side for A*: appends (x,y) entries, exposes a registered read port and count.
// Optional build macro CLOSED_DEDUP_EN adds a linear duplicate scan before each write.
module closed_list_writer #(
    parameter int unsigned DEPTH   = 400,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned IDX_W   = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clear,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    output logic               wr_done,
    output logic               wr_dropped,
    output logic [IDX_W-1:0]   count,
    output logic               full,
    input  logic [IDX_W-1:0]   rd_index,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y
);

    localparam logic [IDX_W-1:0] DepthIdx = IDX_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StScan, StWrite} state_e;

    state_e             state;
    logic [COORD_W-1:0] lat_x;
    logic [COORD_W-1:0] lat_y;
    logic               mem_we;

    logic [COORD_W-1:0] mem_x [DEPTH];
    logic [COORD_W-1:0] mem_y [DEPTH];

    assign wr_ready = (state == StIdle) & ~clear;
    assign full     = (count == DepthIdx);
    // A clear in the write cycle aborts the request, so it also gates the memory write.
    assign mem_we   = (state == StWrite) && !clear && !full;

`ifdef CLOSED_DEDUP_EN
    logic [IDX_W-1:0] scan_idx;
    logic             scan_hit;

    assign scan_hit = (mem_x[scan_idx] == lat_x) && (mem_y[scan_idx] == lat_y);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= StIdle;
            count      <= '0;
            wr_done    <= 1'b0;
            wr_dropped <= 1'b0;
            lat_x      <= '0;
            lat_y      <= '0;
`ifdef CLOSED_DEDUP_EN
            scan_idx   <= '0;
`endif
        end else begin
            wr_done    <= 1'b0;
            wr_dropped <= 1'b0;
            if (clear) begin
                state <= StIdle;
                count <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (wr_valid) begin
                            lat_x <= wr_x;
                            lat_y <= wr_y;
`ifdef CLOSED_DEDUP_EN
                            scan_idx <= '0;
                            state    <= StScan;
`else
                            state    <= StWrite;
`endif
                        end
                    end
                    StScan: begin
`ifdef CLOSED_DEDUP_EN
                        // An empty list still spends one cycle here before writing.
                        if (count == '0) begin
                            state <= StWrite;
                        end else if (scan_hit) begin
                            wr_dropped <= 1'b1;
                            state      <= StIdle;
                        end else if (scan_idx == count - 1'b1) begin
                            state <= StWrite;
                        end else begin
                            scan_idx <= scan_idx + 1'b1;
                        end
`else
                        state <= StIdle;
`endif
                    end
                    StWrite: begin
                        if (full) begin
                            wr_dropped <= 1'b1;
                        end else begin
                            count   <= count + 1'b1;
                            wr_done <= 1'b1;
                        end
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_x[count] <= lat_x;
            mem_y[count] <= lat_y;
        end
    end

    // Read-before-write: a same-index write in this cycle is not visible until the next read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_x <= '0;
            rd_y <= '0;
        end else if (rd_index < DepthIdx) begin
            rd_x <= mem_x[rd_index];
            rd_y <= mem_y[rd_index];
        end else begin
            rd_x <= '0;
            rd_y <= '0;
        end
    end

endmodule

// File: tb/tb_closed_list_writer.sv
// Scoreboard bench for closed_list_writer: a list model predicts each pulse (kind, count, time),
// and a monitor checks them as they appear.
module tb_closed_list_writer;

    localparam int Depth   = 400;
    localparam int CoordW  = 8;
    localparam int IdxW    = 9;
    localparam int WaitMax = 2000;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              clear = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [CoordW-1:0] wr_x = '0;
    logic [CoordW-1:0] wr_y = '0;
    logic              wr_done;
    logic              wr_dropped;
    logic [IdxW-1:0]   count;
    logic              full;
    logic [IdxW-1:0]   rd_index = '0;
    logic [CoordW-1:0] rd_x;
    logic [CoordW-1:0] rd_y;

    closed_list_writer #(
        .DEPTH  (Depth),
        .COORD_W(CoordW),
        .IDX_W  (IdxW)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_done   (wr_done),
        .wr_dropped(wr_dropped),
        .count     (count),
        .full      (full),
        .rd_index  (rd_index),
        .rd_x      (rd_x),
        .rd_y      (rd_y)
    );

    always #5 Clk = ~Clk;

    int edges = 0;
    always @(posedge Clk) edges <= edges + 1;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference list: memory contents persist across clear, only the length resets.
    logic [CoordW-1:0] m_x [Depth];
    logic [CoordW-1:0] m_y [Depth];
    bit                m_written [Depth];
    int                m_cnt = 0;

    typedef struct {
        bit is_done;
        int cnt;
        int at_edge;
    } exp_t;
    exp_t sb[$];

    // acc_edge: index of the clock edge that accepts the request.
    function automatic void model_accept(input logic [CoordW-1:0] x, input logic [CoordW-1:0] y,
                                         input int acc_edge);
        exp_t ex;
        int   extra;
        int   hit;
        hit = -1;
`ifdef CLOSED_DEDUP_EN
        for (int k = 0; k < m_cnt; k++)
            if (hit < 0 && m_x[k] == x && m_y[k] == y) hit = k;
        if (hit >= 0) extra = hit;
        else          extra = (m_cnt == 0) ? 1 : m_cnt;
`else
        extra = 0;
`endif
        if (hit < 0 && m_cnt < Depth) begin
            m_x[m_cnt]       = x;
            m_y[m_cnt]       = y;
            m_written[m_cnt] = 1'b1;
            m_cnt++;
            ex.is_done = 1'b1;
        end else begin
            ex.is_done = 1'b0;
        end
        ex.cnt     = m_cnt;
        ex.at_edge = acc_edge + 1 + extra;
        sb.push_back(ex);
    endfunction

    always @(negedge Clk) begin
        if (!Reset && (wr_done || wr_dropped)) begin
            exp_t ex;
            check("pulse_overlap", int'(wr_done && wr_dropped), 0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'(wr_done) * 2 + int'(wr_dropped), 0);
            end else begin
                ex = sb.pop_front();
                check("pulse_done", int'(wr_done), int'(ex.is_done));
                check("pulse_dropped", int'(wr_dropped), int'(!ex.is_done));
                check("pulse_count", int'(count), ex.cnt);
                check("pulse_full", int'(full), int'(ex.cnt == Depth));
                check("pulse_time", edges, ex.at_edge);
            end
        end
    end

    task automatic do_insert(input logic [CoordW-1:0] x, input logic [CoordW-1:0] y,
                             input bit abort);
        int t;
        @(negedge Clk);
        wr_x     = x;
        wr_y     = y;
        wr_valid = 1'b1;
        t = 0;
        while (!wr_ready && t < WaitMax) begin
            @(negedge Clk);
            t++;
        end
        if (!wr_ready) begin
            check("accept_timeout", 0, 1);
            wr_valid = 1'b0;
            return;
        end
        if (!abort) model_accept(x, y, edges + 1);
        @(posedge Clk);
        #1 wr_valid = 1'b0;
        if (abort) begin
            @(negedge Clk);
            clear = 1'b1;
            @(negedge Clk);
            clear = 1'b0;
            m_cnt = 0;
            #1;
            check("abort_count", int'(count), 0);
            check("abort_ready", int'(wr_ready), 1);
        end
    endtask

    task automatic do_clear();
        @(negedge Clk);
        clear = 1'b1;
        @(negedge Clk);
        clear = 1'b0;
        m_cnt = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < WaitMax) begin
            @(negedge Clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic rd_check(input int idx);
        @(negedge Clk);
        rd_index = IdxW'(idx);
        @(negedge Clk);
        if (idx >= Depth) begin
            check("rd_oob_x", int'(rd_x), 0);
            check("rd_oob_y", int'(rd_y), 0);
        end else if (m_written[idx]) begin
            check("rd_x", int'(rd_x), int'(m_x[idx]));
            check("rd_y", int'(rd_y), int'(m_y[idx]));
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held two cycles
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_count", int'(count), 0);
        check("reset_full", int'(full), 0);
        check("reset_ready", int'(wr_ready), 1);
        check("reset_rd_x", int'(rd_x), 0);
        check("reset_rd_y", int'(rd_y), 0);
        check("reset_done", int'(wr_done), 0);
        check("reset_dropped", int'(wr_dropped), 0);
        Reset = 1'b0;

        // Two inserts and a read-back
        do_insert(8'd3, 8'd5, 1'b0);
        do_insert(8'd7, 8'd2, 1'b0);
        drain();
        check("two_count", int'(count), 2);
        @(negedge Clk);
        rd_index = 9'd1;
        @(negedge Clk);
        check("two_rd_x", int'(rd_x), 7);
        check("two_rd_y", int'(rd_y), 2);

        // Fill to capacity, then one more
        do_clear();
        for (int i = 0; i < Depth; i++)
            do_insert(CoordW'(i % 200), CoordW'(10 + i / 200), 1'b0);
        drain();
        check("fill_count", int'(count), Depth);
        check("fill_full", int'(full), 1);
        do_insert(8'd9, 8'd9, 1'b0);
        drain();
        check("over_count", int'(count), Depth);
        check("over_full", int'(full), 1);
        rd_check(Depth - 1);
        rd_check(Depth);
        rd_check(511);

        // Clear during an in-flight write, then clear together with wr_valid
        do_insert(8'd4, 8'd4, 1'b1);
        @(negedge Clk);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_x     = 8'd5;
        wr_y     = 8'd5;
        #1;
        check("clear_valid_ready", int'(wr_ready), 0);
        @(negedge Clk);
        clear    = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("clear_valid_count", int'(count), 0);
        check("clear_valid_idle", int'(wr_ready), 1);
        repeat (3) @(negedge Clk);
        check("clear_valid_no_write", int'(count), 0);

`ifdef CLOSED_DEDUP_EN
        do_clear();
        do_insert(8'd1, 8'd1, 1'b0);
        do_insert(8'd2, 8'd2, 1'b0);
        do_insert(8'd3, 8'd3, 1'b0);
        drain();
        do_insert(8'd2, 8'd2, 1'b0);
        drain();
        check("dedup_drop_count", int'(count), 3);
        do_insert(8'd6, 8'd6, 1'b0);
        drain();
        check("dedup_new_count", int'(count), 4);
`else
        do_clear();
        do_insert(8'd2, 8'd2, 1'b0);
        do_insert(8'd2, 8'd2, 1'b0);
        drain();
        check("dup_count", int'(count), 2);
        rd_check(0);
        rd_check(1);
        check("dup_rd1_x", int'(rd_x), 2);
        check("dup_rd1_y", int'(rd_y), 2);
`endif

        // Randomized mix of inserts, reads, clears and aborts
        for (int n = 0; n < 150; n++) begin
            int op;
            op = int'($urandom_range(0, 19));
            if (op == 0) begin
                drain();
                do_clear();
            end else if (op < 4) begin
                drain();
                rd_check(int'($urandom_range(0, 511)));
            end else if (op == 4) begin
                drain();
                do_insert(CoordW'($urandom_range(0, 3)), CoordW'($urandom_range(0, 3)), 1'b1);
            end else begin
                do_insert(CoordW'($urandom_range(0, 3)), CoordW'($urandom_range(0, 3)), 1'b0);
                if (op == 5) repeat (int'($urandom_range(1, 3))) @(negedge Clk);
            end
        end
        drain();
        check("final_count", int'(count), m_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
